ssd_scan_sequencer: RTL

//   Scan sequencer for the 6-digit multiplexed seven-segment display in the key/display peripheral.
//   Per-digit slot: blanking dead-time (anti-ghosting), then an active window with 16-level brightness PWM.

---
 rtl/ssd_scan_sequencer.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/ssd_scan_sequencer.sv
// Multiplexed seven-segment scan sequencer: per-digit blanking,
// brightness PWM and frame-aligned double-buffered segment codes.
module ssd_scan_sequencer #(
    parameter int NUM_DIGITS   = 6,
    parameter int DWELL_CYCLES = 100000,
    parameter int BLANK_CYCLES = 1000,
    parameter int CNT_WIDTH    = 17
) (
    input  logic                    i_clk,
    input  logic                    i_reset,
    input  logic                    i_enable,
    input  logic [3:0]              i_brightness,
    input  logic                    i_code_wr_en,
    input  logic [8*NUM_DIGITS-1:0] i_code_wr_data,
    output logic [7:0]              o_segment,
    output logic [NUM_DIGITS-1:0]   o_digital,
    output logic                    o_frame_start,
    output logic                    o_code_applied
);

    localparam int DW = $clog2(NUM_DIGITS);
    localparam int CW = 8 * NUM_DIGITS;
    localparam logic [CNT_WIDTH-1:0] BLANK_LAST = CNT_WIDTH'(BLANK_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] DWELL_LAST = CNT_WIDTH'(DWELL_CYCLES - 1);
    localparam logic [DW-1:0]        DIG_LAST   = DW'(NUM_DIGITS - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_BLANK,
        S_ACTIVE
    } state_t;

    state_t                r_state, w_state;
    logic [CNT_WIDTH-1:0]  r_slot_cnt, w_slot_cnt;
    logic [DW-1:0]         r_digit_idx, w_digit_idx;
    logic [3:0]            r_pwm_cnt, w_pwm_cnt;
    logic                  r_pend_valid, w_pend_valid;
    logic [CW-1:0]         r_pending, w_pending;
    logic [CW-1:0]         r_active, w_active;
    logic [7:0]            r_segment, w_segment;
    logic [NUM_DIGITS-1:0] r_digital, w_digital;
    logic                  r_frame_start, w_frame_start;
    logic                  r_code_applied, w_code_applied;

    // Next-state logic; outputs are decoded from the next state so the
    // pins come straight from flops.
    always_comb begin
        w_state        = r_state;
        w_slot_cnt     = r_slot_cnt;
        w_digit_idx    = r_digit_idx;
        w_pwm_cnt      = r_pwm_cnt;
        w_pending      = r_pending;
        w_pend_valid   = r_pend_valid;
        w_active       = r_active;
        w_frame_start  = 1'b0;
        w_code_applied = 1'b0;
        w_segment      = 8'hFF;
        w_digital      = '1;

        if (i_code_wr_en) begin
            w_pending    = i_code_wr_data;
            w_pend_valid = 1'b1;
        end

        if (!i_enable) begin
            w_state     = S_IDLE;
            w_slot_cnt  = '0;
            w_digit_idx = '0;
            w_pwm_cnt   = '0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    w_state       = S_BLANK;
                    w_slot_cnt    = '0;
                    w_digit_idx   = '0;
                    w_frame_start = 1'b1;
                end
                S_BLANK: begin
                    w_slot_cnt = r_slot_cnt + 1'b1;
                    if (r_slot_cnt == BLANK_LAST) begin
                        w_state   = S_ACTIVE;
                        w_pwm_cnt = '0;
                    end
                end
                S_ACTIVE: begin
                    w_pwm_cnt = r_pwm_cnt + 4'd1;
                    if (r_slot_cnt == DWELL_LAST) begin
                        w_state    = S_BLANK;
                        w_slot_cnt = '0;
                        if (r_digit_idx == DIG_LAST) begin
                            w_digit_idx   = '0;
                            w_frame_start = 1'b1;
                        end else begin
                            w_digit_idx = r_digit_idx + 1'b1;
                        end
                    end else begin
                        w_slot_cnt = r_slot_cnt + 1'b1;
                    end
                end
                default: w_state = S_IDLE;
            endcase
        end

        // Frame boundary: a same-cycle write bypasses the pending buffer.
        if (w_frame_start) begin
            if (i_code_wr_en) begin
                w_active       = i_code_wr_data;
                w_pend_valid   = 1'b0;
                w_code_applied = 1'b1;
            end else if (r_pend_valid) begin
                w_active       = r_pending;
                w_pend_valid   = 1'b0;
                w_code_applied = 1'b1;
            end
        end

        if (w_state == S_ACTIVE) begin
            w_digital[w_digit_idx] = 1'b0;
            if (w_pwm_cnt <= i_brightness)
                w_segment = w_active[8*int'(w_digit_idx) +: 8];
        end
    end

    // State, buffer and output registers with synchronous reset.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state        <= S_IDLE;
            r_slot_cnt     <= '0;
            r_digit_idx    <= '0;
            r_pwm_cnt      <= '0;
            r_pend_valid   <= 1'b0;
            r_pending      <= '1;
            r_active       <= '1;
            r_segment      <= 8'hFF;
            r_digital      <= '1;
            r_frame_start  <= 1'b0;
            r_code_applied <= 1'b0;
        end else begin
            r_state        <= w_state;
            r_slot_cnt     <= w_slot_cnt;
            r_digit_idx    <= w_digit_idx;
            r_pwm_cnt      <= w_pwm_cnt;
            r_pend_valid   <= w_pend_valid;
            r_pending      <= w_pending;
            r_active       <= w_active;
            r_segment      <= w_segment;
            r_digital      <= w_digital;
            r_frame_start  <= w_frame_start;
            r_code_applied <= w_code_applied;
        end
    end

    assign o_segment      = r_segment;
    assign o_digital      = r_digital;
    assign o_frame_start  = r_frame_start;
    assign o_code_applied = r_code_applied;

endmodule
